// File: rtl/min_dist_compare_if.sv
// Handshake/bus bundle between the motion-estimation controller and min_dist_compare.
// master = controller/result consumer side, slave = the comparator.
interface min_dist_compare_if #(
   parameter int NPE    = 16,
   parameter int DIST_W = 16
);
   logic                    start;
   logic                    comp_start;
   logic [NPE-1:0]          pe_ready;
   logic [NPE*DIST_W-1:0]   pe_dist;
   logic [3:0]              vector_x;
   logic [3:0]              vector_y;
   logic                    result_ack;
   logic [DIST_W-1:0]       best_dist;
   logic [3:0]              best_x;
   logic [3:0]              best_y;
   logic                    result_valid;
   logic                    busy;
   logic                    multi_err;

   modport master (
      output start, comp_start, pe_ready, pe_dist, vector_x, vector_y, result_ack,
      input  best_dist, best_x, best_y, result_valid, busy, multi_err
   );

   modport slave (
      input  start, comp_start, pe_ready, pe_dist, vector_x, vector_y, result_ack,
      output best_dist, best_x, best_y, result_valid, busy, multi_err
   );
endinterface

// File: rtl/min_dist_compare.sv
// Minimum-distortion search over NUM_CAND PE strobes; reports best SAD and its motion vector.
// Optional macro COMP_TIEBREAK_ZERO_EN: on equal SAD prefer the candidate with smaller |x|+|y|.
module min_dist_compare #(
   parameter int NPE      = 16,
   parameter int DIST_W   = 16,
   parameter int NUM_CAND = 240
) (
   input  logic                clock,
   input  logic                reset_n,
   min_dist_compare_if.slave   bus
);
   localparam int CNT_W = $clog2(NUM_CAND + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cand_cnt;

   logic                s1_vld;
   logic [DIST_W-1:0]   s1_dist;
   logic [3:0]          s1_x, s1_y;

   logic                min_vld;
   logic [DIST_W-1:0]   min_dist;
   logic [3:0]          min_x, min_y;

   logic                accept, multi, better, upd;
   logic [DIST_W-1:0]   sel_dist, nxt_dist;
   logic [3:0]          nxt_x, nxt_y;

   // Descending scan so the lowest-index set strobe wins.
   always_comb begin
      sel_dist = '0;
      for (int i = NPE - 1; i >= 0; i--)
         if (bus.pe_ready[i]) sel_dist = bus.pe_dist[i*DIST_W +: DIST_W];
   end

   assign accept = (state == RUN) && bus.comp_start && (|bus.pe_ready);
   assign multi  = (bus.pe_ready & (bus.pe_ready - NPE'(1))) != '0;

`ifdef COMP_TIEBREAK_ZERO_EN
   function automatic logic [4:0] mag(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] ax, ay;
      ax = x[3] ? (~x + 4'd1) : x;
      ay = y[3] ? (~y + 4'd1) : y;
      return {1'b0, ax} + {1'b0, ay};
   endfunction

   always_comb begin
      better = s1_dist < min_dist;
      if (s1_dist == min_dist && mag(s1_x, s1_y) < mag(min_x, min_y)) better = 1'b1;
   end
`else
   always_comb begin
      better = s1_dist < min_dist;
   end
`endif

   // The first candidate always lands, so an all-ones search still reports its vector.
   assign upd      = s1_vld && (!min_vld || better);
   assign nxt_dist = upd ? s1_dist : min_dist;
   assign nxt_x    = upd ? s1_x    : min_x;
   assign nxt_y    = upd ? s1_y    : min_y;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= IDLE;
         cand_cnt         <= '0;
         s1_vld           <= 1'b0;
         s1_dist          <= '0;
         s1_x             <= '0;
         s1_y             <= '0;
         min_vld          <= 1'b0;
         min_dist         <= '1;
         min_x            <= '0;
         min_y            <= '0;
         bus.best_dist    <= '0;
         bus.best_x       <= '0;
         bus.best_y       <= '0;
         bus.result_valid <= 1'b0;
         bus.busy         <= 1'b0;
         bus.multi_err    <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_dist <= sel_dist;
            s1_x    <= bus.vector_x;
            s1_y    <= bus.vector_y;
         end
         if (upd) begin
            min_vld  <= 1'b1;
            min_dist <= s1_dist;
            min_x    <= s1_x;
            min_y    <= s1_y;
         end

         case (state)
            IDLE: if (bus.start) begin
               state         <= RUN;
               cand_cnt      <= '0;
               min_vld       <= 1'b0;
               min_dist      <= '1;
               bus.multi_err <= 1'b0;
               bus.busy      <= 1'b1;
            end
            RUN: if (accept) begin
               cand_cnt <= cand_cnt + CNT_W'(1);
               if (multi) bus.multi_err <= 1'b1;
               if (cand_cnt == CNT_W'(NUM_CAND - 1)) state <= FLUSH;
            end
            // Last candidate is still in stage 2 here; load its compare result directly.
            FLUSH: begin
               state            <= DONE;
               bus.busy         <= 1'b0;
               bus.result_valid <= 1'b1;
               bus.best_dist    <= nxt_dist;
               bus.best_x       <= nxt_x;
               bus.best_y       <= nxt_y;
            end
            DONE: if (bus.result_ack) begin
               state            <= IDLE;
               bus.result_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_min_dist_compare.sv
// Directed bench for min_dist_compare: reset abort, min search, ties, multi-strobe, gating, hold.
module tb_min_dist_compare;
   localparam int NPE = 16;
   localparam int DW  = 16;
   localparam int NC  = 240;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   min_dist_compare_if #(.NPE(NPE), .DIST_W(DW)) bus ();

   min_dist_compare #(.NPE(NPE), .DIST_W(DW), .NUM_CAND(NC)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in;
      bus.start      = 1'b0;
      bus.comp_start = 1'b0;
      bus.pe_ready   = '0;
      bus.pe_dist    = '0;
      bus.vector_x   = '0;
      bus.vector_y   = '0;
      bus.result_ack = 1'b0;
   endtask

   // Unselected slices carry a small decoy so a wrong slice choice shows up as a wrong minimum.
   task automatic drive(input logic cs, input logic [NPE-1:0] rdy, input logic [DW-1:0] d,
                        input logic [3:0] x, input logic [3:0] y);
      bus.comp_start = cs;
      bus.pe_ready   = rdy;
      for (int p = 0; p < NPE; p++)
         bus.pe_dist[p*DW +: DW] = rdy[p] ? d : 16'd3;
      bus.vector_x = x;
      bus.vector_y = y;
      tick();
      idle_in();
   endtask

   task automatic start_search;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic ack;
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
   endtask

   initial begin
      logic [NPE-1:0] one;
      int a;
      one = 16'h0001;
      idle_in();

      // reset state
      tick(); tick();
      chk("rst_best_dist", 32'(bus.best_dist), 32'd0);
      chk("rst_best_x", 32'(bus.best_x), 32'd0);
      chk("rst_best_y", 32'(bus.best_y), 32'd0);
      chk("rst_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_multi", 32'(bus.multi_err), 32'd0);
      reset_n = 1'b1;
      tick();

      // 1: abort mid-RUN after 100 strobes
      start_search();
      chk("t1_busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 100; i++) drive(1'b1, one << (i % 16), 16'd7, 4'd1, 4'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t1_busy_after_rst", 32'(bus.busy), 32'd0);
      chk("t1_best_after_rst", 32'(bus.best_dist), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("t1_no_valid", 32'(bus.result_valid), 32'd0);

      // 2: single winner at candidate 57
      start_search();
      for (int i = 0; i < NC; i++)
         if (i == 57) drive(1'b1, one << (i % 16), 16'd12, 4'hD, 4'd2);
         else         drive(1'b1, one << (i % 16), 16'd1000, 4'(i % 5), 4'(i % 3));
      chk("t2_valid_n1", 32'(bus.result_valid), 32'd0);
      chk("t2_busy_flush", 32'(bus.busy), 32'd1);
      tick();
      chk("t2_valid_n2", 32'(bus.result_valid), 32'd1);
      chk("t2_best_dist", 32'(bus.best_dist), 32'd12);
      chk("t2_best_x", 32'(bus.best_x), 32'hD);
      chk("t2_best_y", 32'(bus.best_y), 32'd2);
      chk("t2_busy_done", 32'(bus.busy), 32'd0);
      chk("t2_multi", 32'(bus.multi_err), 32'd0);
      ack();
      chk("t2_valid_ack", 32'(bus.result_valid), 32'd0);

      // 3: equal distortion at (3,3) then (0,0)
      start_search();
      for (int i = 0; i < NC; i++)
         if (i == 10)      drive(1'b1, one << (i % 16), 16'd5, 4'd3, 4'd3);
         else if (i == 20) drive(1'b1, one << (i % 16), 16'd5, 4'd0, 4'd0);
         else              drive(1'b1, one << (i % 16), 16'd900, 4'd1, 4'hF);
      tick();
      chk("t3_valid", 32'(bus.result_valid), 32'd1);
      chk("t3_best_dist", 32'(bus.best_dist), 32'd5);
`ifdef COMP_TIEBREAK_ZERO_EN
      chk("t3_best_x", 32'(bus.best_x), 32'd0);
      chk("t3_best_y", 32'(bus.best_y), 32'd0);
`else
      chk("t3_best_x", 32'(bus.best_x), 32'd3);
      chk("t3_best_y", 32'(bus.best_y), 32'd3);
`endif
      ack();

      // 4: two strobes in one cycle; PE0 (50) must win over PE4 (7)
      start_search();
      bus.comp_start = 1'b1;
      bus.pe_ready   = 16'h0011;
      for (int p = 0; p < NPE; p++) bus.pe_dist[p*DW +: DW] = 16'd3;
      bus.pe_dist[0*DW +: DW] = 16'd50;
      bus.pe_dist[4*DW +: DW] = 16'd7;
      bus.vector_x = 4'd2;
      bus.vector_y = 4'hE;
      tick();
      idle_in();
      chk("t4_multi_set", 32'(bus.multi_err), 32'd1);
      for (int i = 1; i < NC; i++) drive(1'b1, one << (i % 16), 16'd100, 4'd1, 4'd1);
      tick();
      chk("t4_valid", 32'(bus.result_valid), 32'd1);
      chk("t4_best_dist", 32'(bus.best_dist), 32'd50);
      chk("t4_best_x", 32'(bus.best_x), 32'd2);
      chk("t4_best_y", 32'(bus.best_y), 32'hE);
      ack();
      chk("t4_multi_idle", 32'(bus.multi_err), 32'd1);

      // 5: gated strobes (comp_start=0) are ignored and uncounted
      start_search();
      chk("t4_multi_clr", 32'(bus.multi_err), 32'd0);
      a = 0;
      while (a < NC) begin
         if (a % 3 == 0) drive(1'b0, one << (a % 16), 16'd1, 4'd7, 4'd7);
         if (a == NC - 1) begin
            chk("t5_busy_pre", 32'(bus.busy), 32'd1);
            chk("t5_valid_pre", 32'(bus.result_valid), 32'd0);
         end
         drive(1'b1, one << (a % 16), (a == 100) ? 16'd200 : 16'd300, 4'd4, 4'hC);
         a++;
      end
      chk("t5_busy_flush", 32'(bus.busy), 32'd1);
      tick();
      chk("t5_valid", 32'(bus.result_valid), 32'd1);
      chk("t5_best_dist", 32'(bus.best_dist), 32'd200);

      // 6: result held without ack; start is ignored in DONE
      for (int c = 0; c < 20; c++) begin
         bus.start = (c == 10);
         tick();
         bus.start = 1'b0;
         chk("t6_hold_valid", 32'(bus.result_valid), 32'd1);
         chk("t6_hold_dist", 32'(bus.best_dist), 32'd200);
         chk("t6_hold_busy", 32'(bus.busy), 32'd0);
      end
      ack();
      chk("t6_valid_ack", 32'(bus.result_valid), 32'd0);
      chk("t6_busy_idle", 32'(bus.busy), 32'd0);
      chk("t6_dist_kept", 32'(bus.best_dist), 32'd200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
